// File: rtl/glb_bank_arbiter.sv
// rtl/glb_bank_arbiter.sv - round-robin arbiter sharing one GLB bank between NUM_REQ requesters
// Registered bank command, read-tag pipeline routes returning data to the issuing requester.
module glb_bank_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int BANK_ADDR_WIDTH = 17,
  parameter int BANK_DATA_WIDTH = 64,
  parameter int READ_LATENCY    = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ-1:0]                     req_wr_en,
  input  logic [NUM_REQ*BANK_ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*BANK_DATA_WIDTH-1:0]     req_wr_data,
  input  logic [NUM_REQ*(BANK_DATA_WIDTH/8)-1:0] req_wr_strb,
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic                                   bank_rd_en,
  output logic                                   bank_wr_en,
  output logic [BANK_ADDR_WIDTH-1:0]             bank_addr,
  output logic [BANK_DATA_WIDTH-1:0]             bank_wr_data,
  output logic [BANK_DATA_WIDTH/8-1:0]           bank_wr_strb,
  input  logic [BANK_DATA_WIDTH-1:0]             bank_rd_data,
  output logic [NUM_REQ-1:0]                     rsp_valid,
  output logic [BANK_DATA_WIDTH-1:0]             rsp_data
);

  localparam int STRB_W = BANK_DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH  = READ_LATENCY + 1;

  logic [IDX_W-1:0]           ptr_q, ptr_d;
  logic                       hs;
  logic [IDX_W-1:0]           gnt_idx;
  logic                       gnt_wr;

  logic                       bank_rd_en_q, bank_rd_en_d;
  logic                       bank_wr_en_q, bank_wr_en_d;
  logic [BANK_ADDR_WIDTH-1:0] bank_addr_q, bank_addr_d;
  logic [BANK_DATA_WIDTH-1:0] bank_wr_data_q, bank_wr_data_d;
  logic [STRB_W-1:0]          bank_wr_strb_q, bank_wr_strb_d;

  logic [DEPTH-1:0]           tag_vld_q, tag_vld_d;
  logic [IDX_W-1:0]           tag_idx_q [DEPTH];
  logic [IDX_W-1:0]           tag_idx_d [DEPTH];

  // Scan downward so the valid index closest to ptr is the last one written.
  always_comb begin : grant_sel
    int idx;
    hs      = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        hs      = 1'b1;
        gnt_idx = IDX_W'(idx);
      end
    end
    if (reset) hs = 1'b0;
  end

  assign gnt_wr    = req_wr_en[gnt_idx];
  assign req_ready = hs ? (NUM_REQ'(1) << gnt_idx) : '0;

  always_comb begin : next_state
    ptr_d          = ptr_q;
    bank_rd_en_d   = hs & ~gnt_wr;
    bank_wr_en_d   = hs & gnt_wr;
    bank_addr_d    = bank_addr_q;
    bank_wr_data_d = bank_wr_data_q;
    bank_wr_strb_d = bank_wr_strb_q;
    tag_vld_d      = '0;
    for (int s = 0; s < DEPTH; s++) tag_idx_d[s] = '0;

    if (hs) begin
      ptr_d          = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      bank_addr_d    = req_addr[int'(gnt_idx)*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH];
      bank_wr_data_d = req_wr_data[int'(gnt_idx)*BANK_DATA_WIDTH +: BANK_DATA_WIDTH];
      bank_wr_strb_d = req_wr_strb[int'(gnt_idx)*STRB_W +: STRB_W];
    end

    tag_vld_d[0] = bank_rd_en_d;
    tag_idx_d[0] = gnt_idx;
    for (int s = 1; s < DEPTH; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q          <= '0;
      bank_rd_en_q   <= 1'b0;
      bank_wr_en_q   <= 1'b0;
      bank_addr_q    <= '0;
      bank_wr_data_q <= '0;
      bank_wr_strb_q <= '0;
      tag_vld_q      <= '0;
      for (int s = 0; s < DEPTH; s++) tag_idx_q[s] <= '0;
    end else begin
      ptr_q          <= ptr_d;
      bank_rd_en_q   <= bank_rd_en_d;
      bank_wr_en_q   <= bank_wr_en_d;
      bank_addr_q    <= bank_addr_d;
      bank_wr_data_q <= bank_wr_data_d;
      bank_wr_strb_q <= bank_wr_strb_d;
      tag_vld_q      <= tag_vld_d;
      for (int s = 0; s < DEPTH; s++) tag_idx_q[s] <= tag_idx_d[s];
    end
  end

  assign bank_rd_en   = bank_rd_en_q;
  assign bank_wr_en   = bank_wr_en_q;
  assign bank_addr    = bank_addr_q;
  assign bank_wr_data = bank_wr_data_q;
  assign bank_wr_strb = bank_wr_strb_q;

  // The last tag stage lines up with the bank's read data.
  assign rsp_valid = (tag_vld_q[DEPTH-1] && !reset) ? (NUM_REQ'(1) << tag_idx_q[DEPTH-1]) : '0;
  assign rsp_data  = bank_rd_data;

endmodule
